// File: rtl/can_pkg.sv
// Shared CAN definitions: CRC-15 constants and
// receive CRC checker state encoding.
package can_pkg;

  localparam int CAN_CRC_W = 15;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {
    CRC_IDLE,
    CRC_CALC,
    CRC_CRCF,
    CRC_DELIM
  } crc_state_e;

endpackage

// File: rtl/can_crc15_step.sv
// Single-bit CRC-15 LFSR update, shared by the
// transmit and receive CRC paths.
module can_crc15_step
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] POLY = CAN_CRC_POLY
) (
  input  logic [CAN_CRC_W-1:0] lfsr,
  input  logic                 bit_in,
  output logic [CAN_CRC_W-1:0] lfsr_next
);

  logic fb;

  always_comb begin
    fb = bit_in ^ lfsr[CAN_CRC_W-1];
    lfsr_next = {lfsr[CAN_CRC_W-2:0], 1'b0};
    if (fb) lfsr_next = lfsr_next ^ POLY;
  end

endmodule

// File: rtl/can_crc_check.sv
// Receive-side CRC-15 checker: runs the LFSR over the
// covered field, then compares the received CRC field.
module can_crc_check
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] POLY = CAN_CRC_POLY,
  parameter logic [CAN_CRC_W-1:0] INIT = '0,
  parameter int LEN_W = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_ok,
  output logic                 crc_err,
  output logic                 form_err,
  output logic [CAN_CRC_W-1:0] crc_calc
);

  // Counter must also reach 14 while in the CRC field
  localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;

  crc_state_e           state;
  logic [CAN_CRC_W-1:0] lfsr;
  logic [CAN_CRC_W-1:0] lfsr_nxt;
  logic [CAN_CRC_W-1:0] rx_crc;
  logic [LEN_W-1:0]     len_q;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;

  can_crc15_step #(
    .POLY (POLY)
  ) u_step (
    .lfsr      (lfsr),
    .bit_in    (bit_in),
    .lfsr_next (lfsr_nxt)
  );

  assign cnt_nxt  = cnt + CNT_W'(1);
  assign crc_calc = lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CRC_IDLE;
      lfsr     <= INIT;
      rx_crc   <= '0;
      len_q    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      form_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= CRC_IDLE;
        busy     <= 1'b0;
        crc_ok   <= 1'b0;
        crc_err  <= 1'b0;
        form_err <= 1'b0;
      end else if (start) begin
        lfsr     <= INIT;
        cnt      <= '0;
        len_q    <= len;
        rx_crc   <= '0;
        busy     <= 1'b1;
        crc_ok   <= 1'b0;
        crc_err  <= 1'b0;
        form_err <= 1'b0;
        state    <= (len == '0) ? CRC_CRCF : CRC_CALC;
      end else if (bit_valid) begin
        unique case (state)
          CRC_IDLE: ;
          CRC_CALC: begin
            lfsr <= lfsr_nxt;
            if (cnt_nxt == CNT_W'(len_q)) begin
              cnt   <= '0;
              state <= CRC_CRCF;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          CRC_CRCF: begin
            rx_crc <= {rx_crc[CAN_CRC_W-2:0], bit_in};
            cnt    <= cnt_nxt;
            if (cnt == CNT_W'(CAN_CRC_W - 1)) state <= CRC_DELIM;
          end
          CRC_DELIM: begin
            crc_ok   <= (rx_crc == lfsr);
            crc_err  <= (rx_crc != lfsr);
            form_err <= ~bit_in;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= CRC_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_crc_check.sv
// Randomized bench for can_crc_check against a
// polynomial long-division CRC reference.
module tb_can_crc_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  len = '0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        form_err;
  logic [14:0] crc_calc;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  can_crc_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .form_err  (form_err),
    .crc_calc  (crc_calc)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Remainder of M(x)*x^15 divided by the generator polynomial
  function automatic logic [14:0] crc_ref(input bit msg[$]);
    bit m[$];
    logic [15:0] g;
    logic [14:0] r;
    g = 16'hC599;
    m = msg;
    for (int i = 0; i < 15; i++) m.push_back(1'b0);
    for (int i = 0; i + 15 < m.size(); i++)
      if (m[i])
        for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
    for (int i = 0; i < 15; i++) r[14-i] = m[m.size()-15+i];
    return r;
  endfunction

  task automatic send_bit(input bit b, input int gap_max);
    int gap;
    gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    repeat (gap) @(negedge clk);
    bit_valid = 1'b1;
    bit_in = b;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic do_start(input int l, input bit bv_too);
    start = 1'b1;
    len = 7'(l);
    bit_valid = bv_too;
    bit_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bit_valid = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic run_frame(input string tag, input bit msg[$],
                           input logic [14:0] rx, input bit delim,
                           input int gap_max, input bit bv_start);
    logic [14:0] exp_crc;
    int d0;
    exp_crc = crc_ref(msg);
    do_start(msg.size(), bv_start);
    d0 = done_cnt;
    foreach (msg[i]) send_bit(msg[i], gap_max);
    for (int i = 14; i >= 0; i--) send_bit(rx[i], gap_max);
    chk({tag, "_calc_frozen"}, crc_calc, exp_crc);
    chk({tag, "_no_early_done"}, done_cnt - d0, 0);
    send_bit(delim, gap_max);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_drop"}, busy, 0);
    chk({tag, "_crc_calc"}, crc_calc, exp_crc);
    chk({tag, "_crc_ok"}, crc_ok, rx == exp_crc);
    chk({tag, "_crc_err"}, crc_err, rx != exp_crc);
    chk({tag, "_form_err"}, form_err, !delim);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ok_held"}, crc_ok, rx == exp_crc);
  endtask

  initial begin
    bit msg[$];
    bit one[$];
    logic [14:0] c;
    int d0;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ok", crc_ok, 0);
    chk("rst_err", crc_err, 0);
    chk("rst_form", form_err, 0);
    chk("rst_calc", crc_calc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_bit(1'b1, 0);
    chk("idle_bit_ignored", crc_calc, 0);

    one = {1'b1};
    chk("ref_sanity", crc_ref(one), 15'h4599);
    run_frame("s1", one, 15'b100010110011001, 1'b1, 0, 1'b0);

    msg.delete();
    repeat (83) msg.push_back(1'b0);
    run_frame("zeros", msg, 15'h0, 1'b1, 0, 1'b0);

    run_frame("flip7", one, 15'b100010110011001 ^ 15'h0080, 1'b1, 0, 1'b0);
    run_frame("delim0", one, 15'b100010110011001, 1'b0, 0, 1'b0);
    run_frame("gaps", one, 15'b100010110011001, 1'b1, 5, 1'b0);

    msg.delete();
    run_frame("len0", msg, 15'h0, 1'b1, 1, 1'b0);

    // Abort during the 8th CRC bit
    d0 = done_cnt;
    do_start(1, 1'b0);
    send_bit(1'b1, 0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 0);
    abort = 1'b1;
    bit_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bit_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ok", crc_ok, 0);
    chk("abort_err", crc_err, 0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    chk("abort_no_done", done_cnt - d0, 0);

    // Restart at covered bit 40, strobe coincident with start
    d0 = done_cnt;
    do_start(83, 1'b0);
    for (int i = 0; i < 39; i++) send_bit($urandom_range(1, 0), 0);
    msg.delete();
    for (int i = 0; i < 60; i++) msg.push_back($urandom_range(1, 0));
    c = crc_ref(msg);
    run_frame("restart", msg, c, 1'b1, 2, 1'b1);
    chk("restart_one_done", done_cnt - d0, 1);

    for (int f = 0; f < 8; f++) begin
      int l;
      l = $urandom_range(103, 1);
      msg.delete();
      for (int i = 0; i < l; i++) msg.push_back($urandom_range(1, 0));
      c = crc_ref(msg);
      if ($urandom_range(1, 0)) c = c ^ 15'(1 << $urandom_range(14, 0));
      run_frame($sformatf("rnd%0d", f), msg, c,
                $urandom_range(3, 0) != 0, $urandom_range(3, 0), 1'b0);
    end

    // Mid-frame reset
    d0 = done_cnt;
    do_start(20, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_calc", crc_calc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) send_bit(1'b1, 0);
    chk("mid_rst_no_done", done_cnt - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/can_crc_check.md
# can_crc_check

Receive-side CRC-15 checker for the CAN controller. It consumes the destuffed receive bitstream one bit per `bit_valid` strobe and runs the CAN generator polynomial over the covered field (SOF through data). It then captures the 15 transmitted CRC bits, compares them against the computed remainder, and samples the CRC delimiter. It sits between the bit destuffer and the receive frame FSM, which supplies `start`/`len` and consumes `done`/`crc_ok`/`crc_err`/`form_err`.

## Interface
- `POLY`, default 15'h4599: generator x^15+x^14+x^10+x^8+x^7+x^4+x^3+1, with the x^15 term implicit.
- `INIT`, default 15'h0000: LFSR value loaded on `start`.
- `LEN_W`, default 7: width of `len`. Covers up to 127 bits; an extended frame needs 103.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a new check and latches `len`.
- `len`  in  LEN_W  number of covered bits preceding the CRC field.
- `bit_valid`  in  1  one destuffed bit is present on `bit_in` this cycle.
- `bit_in`  in  1  received bit (1 = recessive).
- `abort`  in  1  error/bus-off from the frame FSM; drops the current check.
- `busy`  out  1  check in progress.
- `done`  out  1  single-cycle pulse; verdict outputs are valid.
- `crc_ok`  out  1  received CRC equals computed CRC; held until the next `start`.
- `crc_err`  out  1  mismatch; held until the next `start`.
- `form_err`  out  1  CRC delimiter sampled as 0; held until the next `start`.
- `crc_calc`  out  15  computed remainder; frozen once the CRC field begins.

## Operation
- States: IDLE, CALC, CRCF, DELIM.
- IDLE:
  - `start` → load LFSR=INIT, bit counter=0, latched len=`len`, rx_crc=0.
  - Clear `crc_ok`/`crc_err`/`form_err`.
  - Next state is CALC, or CRCF if `len`==0.
- CALC, on each `bit_valid`:
  - fb = bit_in ^ lfsr[14]; lfsr = {lfsr[13:0],1'b0} ^ (fb ? POLY : 0); count+1.
  - When count reaches the latched len, go to CRCF and reset count to 0.
- CRCF, on each `bit_valid`:
  - rx_crc = {rx_crc[13:0], bit_in} (MSB first); LFSR holds its value; count+1.
  - After the 15th bit, go to DELIM.
- DELIM, on the next `bit_valid`:
  - `crc_ok` = (rx_crc == lfsr); `crc_err` = its complement; `form_err` = ~bit_in.
  - Pulse `done`, return to IDLE.
- Cycles without `bit_valid` hold all state.
- `start` in any non-IDLE state restarts the check exactly as from IDLE. No `done` is produced for the dropped frame.
- `abort` in any state → IDLE. Verdict outputs are cleared and there is no `done`. If `abort` and `start` occur together, `abort` wins.
- `bit_valid` in the same cycle as `start` is ignored; the first covered bit is the next strobe.
- `bit_valid` in IDLE is ignored.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, LFSR=INIT, `busy`=0, `done`=0, `crc_ok`=0, `crc_err`=0, `form_err`=0, `crc_calc`=INIT.
- All outputs are registered.
- `busy` rises the cycle after `start`.
- `done`, verdicts and the drop of `busy` all appear the cycle after the delimiter strobe.
- Back-to-back bits are supported: `bit_valid` may be high every cycle, for a throughput of one bit per clock.
- `start` is legal in the same cycle that `done` is high.
- Reset asserted mid-frame returns immediately to the reset values; no `done`.

## Structure
- Shared package `can_pkg` holds:
  - `CAN_CRC_W`=15 and `CAN_CRC_POLY`=15'h4599 (shared with the transmit CRC generator).
  - The state enum for this block.
- Sub-module `can_crc15_step`: combinational single-bit LFSR update (lfsr, bit → lfsr_next). Parameterised by POLY and reused by the transmit side.

## Test plan
- len=1, bit 1; then CRC bits 100010110011001; delimiter 1 → `crc_calc`=15'h4599, `done` pulse, `crc_ok`=1, `crc_err`=0, `form_err`=0.
- len=83, all bits 0; CRC field all 0; delimiter 1 → `crc_calc`=0, `crc_ok`=1.
- Same as the first scenario with CRC bit 7 flipped → `crc_err`=1, `crc_ok`=0.
- Same as the first scenario with delimiter 0 → `crc_ok`=1 and `form_err`=1.
- Random gaps in `bit_valid` (0–5 idle cycles) on the first scenario → identical results; `done` occurs exactly one cycle after the delimiter strobe.
- `abort` during the 8th CRC bit → `busy`=0 next cycle, no `done`, verdicts 0. `start` at covered bit 40 → restart; only one `done`, and it reflects the second frame.
